parking_keypad_entry: RTL and testbench

Keypad front-end for the parking entry controller. It debounces raw key presses from the keypad scanner and assembles up to two decimal digits into an 8-bit binary password (d1*10 + d0). It then presents the value on psswrd_atmpt with a one-cycle try_psswrd strobe. It is the transmitter side of the controller's password-attempt interface.

---
 rtl/parking_keypad_entry.sv | 182 ++++++++++++++++++
 tb/tb_parking_keypad_entry.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_keypad_entry.sv
// Keypad front-end: synchronizes and debounces raw key presses, assembles up to
// two decimal digits into a binary password and strobes it out on ENTER.
module parking_keypad_entry #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic [7:0] psswrd_atmpt,
    output logic       try_psswrd,
    output logic [1:0] digit_count,
    output logic       entry_error,
    output logic       busy,
    output logic [1:0] dbg_key_state_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        K_WAIT_RELEASE = 2'd0,
        K_RELEASED     = 2'd1,
        K_WAIT_PRESS   = 2'd2,
        K_PRESSED      = 2'd3
    } key_state_t;

    typedef enum logic [1:0] {
        E_IDLE = 2'd0,
        E_D1   = 2'd1,
        E_D2   = 2'd2
    } entry_state_t;

    logic         ks_meta_q, ks_q;
    key_state_t   key_q, key_d;
    logic [CW-1:0] dcnt_q, dcnt_d;
    logic         press_evt;
    logic         evt_q;
    logic [3:0]   code_q;

    entry_state_t ent_q, ent_d;
    logic [7:0]   acc_q, acc_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]   pw_q, pw_d;
    logic         try_q, try_d;
    logic         err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            ks_meta_q <= 1'b0;
            ks_q      <= 1'b0;
            key_q     <= K_WAIT_RELEASE;
            dcnt_q    <= '0;
            evt_q     <= 1'b0;
            code_q    <= 4'd0;
            ent_q     <= E_IDLE;
            acc_q     <= 8'd0;
            tmo_q     <= '0;
            pw_q      <= 8'd0;
            try_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ks_meta_q <= key_valid;
            ks_q      <= ks_meta_q;
            key_q     <= key_d;
            dcnt_q    <= dcnt_d;
            evt_q     <= press_evt;
            if (press_evt) begin
                code_q <= key_code;
            end
            ent_q     <= ent_d;
            acc_q     <= acc_d;
            tmo_q     <= tmo_d;
            pw_q      <= pw_d;
            try_q     <= try_d;
            err_q     <= err_d;
        end
    end

    // Debounce: a press is only armed after a debounced release, so holding never repeats.
    always_comb begin
        key_d     = key_q;
        dcnt_d    = dcnt_q;
        press_evt = 1'b0;
        case (key_q)
            K_WAIT_RELEASE: begin
                if (ks_q) begin
                    dcnt_d = '0;
                end else if (dcnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    key_d  = K_RELEASED;
                    dcnt_d = '0;
                end else begin
                    dcnt_d = dcnt_q + CW'(1);
                end
            end
            K_RELEASED: begin
                if (ks_q) begin
                    key_d  = K_WAIT_PRESS;
                    dcnt_d = CW'(1);
                end
            end
            K_WAIT_PRESS: begin
                if (!ks_q) begin
                    key_d  = K_RELEASED;
                    dcnt_d = '0;
                end else if (dcnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                    press_evt = 1'b1;
                    key_d     = K_PRESSED;
                    dcnt_d    = '0;
                end else begin
                    dcnt_d = dcnt_q + CW'(1);
                end
            end
            K_PRESSED: begin
                if (!ks_q) begin
                    key_d  = K_WAIT_RELEASE;
                    dcnt_d = CW'(1);
                end
            end
            default: begin
                key_d  = K_WAIT_RELEASE;
                dcnt_d = '0;
            end
        endcase
    end

    // Entry: a registered key event outranks a timeout landing in the same cycle.
    always_comb begin
        ent_d = ent_q;
        acc_d = acc_q;
        tmo_d = tmo_q;
        pw_d  = pw_q;
        try_d = 1'b0;
        err_d = 1'b0;
        if (evt_q) begin
            tmo_d = '0;
            if (code_q <= 4'd9) begin
                case (ent_q)
                    E_IDLE: begin
                        acc_d = {4'd0, code_q};
                        ent_d = E_D1;
                    end
                    E_D1: begin
                        acc_d = acc_q * 8'd10 + {4'd0, code_q};
                        ent_d = E_D2;
                    end
                    default: err_d = 1'b1;
                endcase
            end else if (code_q == 4'hA) begin
                acc_d = 8'd0;
                ent_d = E_IDLE;
            end else if (code_q == 4'hB) begin
                if (ent_q != E_IDLE) begin
                    pw_d  = acc_q;
                    try_d = 1'b1;
                    acc_d = 8'd0;
                    ent_d = E_IDLE;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (ent_q != E_IDLE) begin
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_d = '0;
                acc_d = 8'd0;
                ent_d = E_IDLE;
                err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    assign psswrd_atmpt    = pw_q;
    assign try_psswrd      = try_q;
    assign entry_error     = err_q;
    assign digit_count     = ent_q;
    assign busy            = (ent_q != E_IDLE);
    assign dbg_key_state_o = key_q;
endmodule

// File: tb/tb_parking_keypad_entry.sv
// Bench for parking_keypad_entry: directed scenarios plus random keypad traffic,
// all checked every cycle against a run-length / digit-queue model.
module tb_parking_keypad_entry;
  localparam int DEB = 4;
  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [7:0] psswrd_atmpt;
  logic       try_psswrd;
  logic [1:0] digit_count;
  logic       entry_error;
  logic       busy;
  logic [1:0] dbg_key_state;

  parking_keypad_entry #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_valid(key_valid),
    .key_code(key_code),
    .psswrd_atmpt(psswrd_atmpt),
    .try_psswrd(try_psswrd),
    .digit_count(digit_count),
    .entry_error(entry_error),
    .busy(busy),
    .dbg_key_state_o(dbg_key_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  int n_try = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Model: synchronizer as two delayed samples, debounce as zero/one run lengths
  // with an "armed" flag, and the entry buffer as a queue of decimal digits.
  int         ks1, ks2, zero_run, ones_run, idle;
  bit         armed, pend, started;
  logic [3:0] pend_code;
  int         digits[$];
  logic [7:0] m_pw;
  bit         m_try, m_err;

  always @(posedge clk) begin
    int val;
    if (rst) begin
      ks1 = 0; ks2 = 0; zero_run = 0; ones_run = 0; idle = 0;
      armed = 0; pend = 0; pend_code = 4'd0;
      digits.delete();
      m_pw = 8'd0; m_try = 0; m_err = 0;
      started = 1;
    end else begin
      m_try = 0;
      m_err = 0;
      if (pend) begin
        idle = 0;
        if (pend_code < 4'd10) begin
          if (digits.size() < 2) digits.push_back(int'(pend_code));
          else m_err = 1;
        end else if (pend_code == 4'hA) begin
          digits.delete();
        end else if (pend_code == 4'hB) begin
          if (digits.size() > 0) begin
            val = 0;
            foreach (digits[i]) val = val * 10 + digits[i];
            m_pw = 8'(val);
            m_try = 1;
            digits.delete();
          end else begin
            m_err = 1;
          end
        end
      end else if (digits.size() > 0) begin
        idle++;
        if (idle == TMO) begin
          digits.delete();
          m_err = 1;
          idle = 0;
        end
      end
      if (digits.size() == 0) idle = 0;
      pend = 0;
      if (ks2 != 0) begin
        zero_run = 0;
        ones_run++;
        if (armed && ones_run == DEB) begin
          pend = 1;
          pend_code = key_code;
          armed = 0;
        end
      end else begin
        ones_run = 0;
        zero_run++;
        if (zero_run == DEB) armed = 1;
      end
      ks2 = ks1;
      ks1 = int'(key_valid);
    end
  end

  // Compare process: every cycle after the first reset edge.
  always @(negedge clk) begin
    if (started) begin
      check("outputs {pw,try,err,cnt,busy}",
            {19'd0, psswrd_atmpt, try_psswrd, entry_error, digit_count, busy},
            {19'd0, m_pw, m_try, m_err, 2'(digits.size()), digits.size() != 0});
      if (try_psswrd === 1'b1) n_try++;
      if (entry_error === 1'b1) n_err++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] code, input int hold = 8, input int rel = 8);
    key_code = code;
    key_valid = 1'b1;
    cycles(hold);
    key_valid = 1'b0;
    cycles(rel);
  endtask

  task automatic pulse(input int hi, input int lo);
    key_valid = 1'b1;
    cycles(hi);
    key_valid = 1'b0;
    cycles(lo);
  endtask

  initial begin
    int t0, e0, r;
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(10);
    check("reset pw", psswrd_atmpt, 8'h00);
    check("reset cnt", digit_count, 2'd0);

    // 8, 7, ENTER
    t0 = n_try;
    press(4'd8); press(4'd7);
    check("cnt after 8,7", digit_count, 2'd2);
    press(4'hB);
    check("try count 87", n_try - t0, 1);
    check("pw 57 dut", psswrd_atmpt, 8'h57);
    check("pw 57 model", m_pw, 8'h57);
    cycles(20);
    check("pw 57 held", psswrd_atmpt, 8'h57);
    check("cnt after enter", digit_count, 2'd0);

    // Bounce then glitch
    key_code = 4'd3;
    pulse(2, 1); pulse(6, 8);
    check("bounce one digit", digit_count, 2'd1);
    press(4'hA);
    key_code = 4'd3;
    pulse(3, 8);
    check("glitch ignored", digit_count, 2'd0);

    // 1, 2, 3, ENTER
    t0 = n_try; e0 = n_err;
    press(4'd1); press(4'd2); press(4'd3);
    check("third digit error", n_err - e0, 1);
    press(4'hB);
    check("try count 123", n_try - t0, 1);
    check("pw 0C dut", psswrd_atmpt, 8'h0C);
    check("pw 0C model", m_pw, 8'h0C);

    // ENTER empty; 4, CLEAR, ENTER
    t0 = n_try; e0 = n_err;
    press(4'hB);
    check("empty enter error", n_err - e0, 1);
    press(4'd4); press(4'hA); press(4'hB);
    check("clear enter error", n_err - e0, 2);
    check("no try on empty", n_try - t0, 0);
    check("pw unchanged", psswrd_atmpt, 8'h0C);

    // Timeout
    e0 = n_err;
    press(4'd5);
    cycles(TMO + 10);
    check("timeout error", n_err - e0, 1);
    check("timeout cnt", digit_count, 2'd0);
    press(4'd9); press(4'd9); press(4'hB);
    check("pw 63 dut", psswrd_atmpt, 8'h63);
    check("pw 63 model", m_pw, 8'h63);

    // Reset while a key is held
    t0 = n_try; e0 = n_err;
    key_code = 4'd6;
    key_valid = 1'b1;
    cycles(3);
    rst = 1'b1;
    cycles(3);
    rst = 1'b0;
    cycles(12);
    key_valid = 1'b0;
    cycles(8);
    check("held through reset cnt", digit_count, 2'd0);
    check("held through reset err", n_err - e0, 0);
    press(4'd6); press(4'hB);
    check("pw 06 dut", psswrd_atmpt, 8'h06);
    check("try after reset", n_try - t0, 1);

    // Random traffic with bounce, odd codes, timeouts and occasional reset
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60) key_code = 4'($urandom_range(0, 9));
      else if (r < 75) key_code = 4'hB;
      else if (r < 85) key_code = 4'hA;
      else key_code = 4'($urandom_range(12, 15));
      if ($urandom_range(0, 3) == 0) begin
        for (int b = 0; b < int'($urandom_range(1, 3)); b++)
          pulse($urandom_range(1, 3), $urandom_range(1, 2));
      end
      pulse($urandom_range(1, 10), $urandom_range(1, 10));
      if ($urandom_range(0, 19) == 0) cycles(TMO + $urandom_range(0, 8));
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        cycles($urandom_range(1, 3));
        rst = 1'b0;
      end
    end
    key_valid = 1'b0;
    cycles(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
